// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the countdown timer controller.
//   - st_e        : FSM state encoding, also driven out on the state port
//   - ST_W        : width of the state encoding
//   - TICK_DIV_DEFAULT : clk cycles per tick for a 500 ms tick at 100 MHz
package countdown_timer_ctrl_pkg;

  localparam int ST_W             = 2;
  localparam int TICK_DIV_DEFAULT = 50_000_000;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } st_e;

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// Prescaler producing a single-cycle tick enable every TICK_DIV clk cycles.
// The count holds while en is low, so a paused timer keeps its partial period.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-high
//   en    in   advance the prescaler this cycle
//   clr   in   force the prescaler back to the start of a period
//   wrap  out  combinational: the coming edge is a tick edge
//   tick  out  registered one-cycle pulse following each wrap
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap,
  output logic tick
);

  localparam int              PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_tick;

  // The parent updates its counter on the same edge that tick rises, so it
  // needs the terminal-count condition ahead of the registered pulse.
  assign wrap = en && !clr && (r_pre_cnt == LAST);
  assign tick = r_tick;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (clr) begin
        r_pre_cnt <= '0;
      end else if (wrap) begin
        r_pre_cnt <= '0;
        r_tick    <= 1'b1;
      end else if (en) begin
        r_pre_cnt <= r_pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: start/pause/resume/clear FSM around a prescaled
// timebase and a down-counter. Signals expiry with a done pulse and a blink
// output that toggles on every tick while expired.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   start      in   load-and-start, resume from pause, or restart after expiry
//   pause      in   freeze the count while running
//   clear      in   abort to IDLE
//   load_val   in   initial count, sampled only on an accepted load
//   tick       out  one-cycle pulse at each prescaler wrap
//   remaining  out  current count
//   state      out  FSM state (IDLE=0, RUN=1, PAUSE=2, EXPIRED=3)
//   busy       out  high in RUN or PAUSE
//   done       out  one-cycle pulse on entry to EXPIRED
//   blink      out  toggles on each tick while in EXPIRED
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic [ST_W-1:0]  state,
  output logic             busy,
  output logic             done,
  output logic             blink
);

  st_e              r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_blink;

  logic w_load;
  logic w_pre_en;
  logic w_pre_clr;
  logic w_wrap;

  // clear > pause > start; a load is only accepted from IDLE or EXPIRED.
  assign w_load    = start && !pause && !clear &&
                     ((r_state == ST_IDLE) || (r_state == ST_EXPIRED));
  assign w_pre_en  = (r_state == ST_RUN) || (r_state == ST_EXPIRED);
  assign w_pre_clr = clear || w_load;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_pre_en),
    .clr  (w_pre_clr),
    .wrap (w_wrap),
    .tick (tick)
  );

  assign remaining = r_remaining;
  assign state     = r_state;
  assign busy      = r_busy;
  assign done      = r_done;
  assign blink     = r_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      // NOTE: done defaults low every cycle so it can only ever be a
      // single-cycle pulse; branches below override it on EXPIRED entry.
      r_done <= 1'b0;
      if (clear) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
        r_busy      <= 1'b0;
        r_blink     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_EXPIRED: begin
            if ((r_state == ST_EXPIRED) && w_wrap) begin
              r_blink <= ~r_blink;
            end
            // A load overrides the blink toggle above.
            if (w_load) begin
              r_blink <= 1'b0;
              if (load_val != '0) begin
                r_state     <= ST_RUN;
                r_remaining <= load_val;
                r_busy      <= 1'b1;
              end else begin
                r_state     <= ST_EXPIRED;
                r_remaining <= '0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            // The decrement on a tick edge takes precedence over pause, so
            // reaching zero lands in EXPIRED even with pause asserted.
            if (w_wrap && (r_remaining != '0)) begin
              if (r_remaining == CNT_W'(1)) begin
                r_remaining <= '0;
                r_state     <= ST_EXPIRED;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
              end else begin
                r_remaining <= r_remaining - CNT_W'(1);
                if (pause) begin
                  r_state <= ST_PAUSE;
                end
              end
            end else if (pause) begin
              r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (start && !pause) begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Sequences a prescaled timebase and a countdown counter for the board-level timer and game projects.
- Generates single-cycle tick enables from the system clock; no derived clocks.
- Runs a start/pause/resume/clear state machine, counts a loaded value down to zero, and signals expiry with a done pulse and a blink output.
- Sits between the button/switch debouncers and the display driver.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per tick (500 ms at 100 MHz). Must be ≥2.
- CNT_W, 16: width of the load value and the remaining count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level, sampled each cycle. Loads and starts the count, resumes from pause, or restarts after expiry.
- pause  in  1  level, sampled each cycle. Freezes the count while in RUN.
- clear  in  1  level, sampled each cycle. Aborts to IDLE.
- load_val  in  CNT_W  initial count, sampled only on an accepted load.
- tick  out  1  one-cycle pulse at each prescaler wrap.
- remaining  out  CNT_W  current count.
- state  out  2  FSM state, encoded IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle pulse when the count reaches zero.
- blink  out  1  toggles on each tick while in EXPIRED.

Behaviour:
- Reset: asynchronous, active-high, affects every register.
  - Values: state=IDLE, pre_cnt=0, tick=0, remaining=0, done=0, blink=0, busy=0.
- Outputs: all registered; no combinational path from any input to any output.
- Prescaler: pre_cnt counts 0..TICK_DIV-1 while enabled.
  - On the edge where pre_cnt==TICK_DIV-1, pre_cnt←0 and tick←1. tick is 0 on all other cycles.
  - Enabled in RUN and EXPIRED. Held, not cleared, in PAUSE, so a resume keeps the partial period.
  - Forced to 0 on every load and on clear.
- Input priority per cycle: clear > pause > start.
- IDLE:
  - start with load_val≠0 → RUN; remaining←load_val; pre_cnt←0.
  - start with load_val==0 → EXPIRED; done←1; remaining stays 0.
- RUN:
  - On each tick edge, remaining←remaining-1 on the same edge, so the new count is visible in the cycle where tick=1.
  - If remaining==1 at the tick edge: remaining←0, state←EXPIRED, done←1 on the same edge.
  - pause → PAUSE.
  - pause on a tick edge: the decrement is applied first. If it reaches zero, EXPIRED wins over PAUSE.
  - start in RUN is ignored; there is no mid-run reload.
- PAUSE:
  - remaining and pre_cnt hold.
  - start with pause low → RUN, continuing from the held pre_cnt.
  - start with pause high → stays in PAUSE.
- EXPIRED:
  - remaining=0; blink toggles on each tick.
  - start → same load rules as IDLE, with blink←0. A zero load re-enters EXPIRED and pulses done again.
  - done fires only on entry to EXPIRED.
- clear, from any state, at the next edge:
  - state←IDLE, remaining←0, pre_cnt←0, tick←0, blink←0.
  - Any done pulse in flight is suppressed.
- Arithmetic and width:
  - pre_cnt is $clog2(TICK_DIV) bits.
  - remaining never wraps below 0; it never decrements when already 0.
- Level-held start: after reaching RUN, a still-high start has no effect. An external edge detector supplies pulses.

Decomposition:
- Shared package/header holds:
  - state localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED;
  - the 2-bit state width;
  - the default TICK_DIV for 100 MHz.
- One sub-module, tick_prescaler:
  - Inputs: clk, rst, en, clr.
  - Outputs: tick.
  - Parameter: TICK_DIV.
  - Instantiated once.
- The FSM and the remaining counter stay in the top module.

Test Plan (run with TICK_DIV=4, CNT_W=8):
- Reset mid-run: assert rst asynchronously while in RUN with remaining=5 → all outputs 0 and state=IDLE immediately, before the next clk edge.
- Basic countdown: load_val=3, pulse start 1 cycle → state=RUN next cycle; remaining 3→2→1→0 on ticks 4 cycles apart; done=1 for exactly 1 cycle together with remaining=0; state=EXPIRED.
- Pause/resume partial period: load_val=2, start; assert pause 2 cycles after a tick for 10 cycles → remaining stays 1 and tick stays 0; release pause and pulse start → next tick arrives 2 cycles after the resume edge.
- Same-cycle events: pause asserted on the tick edge where remaining goes 1→0 → state=EXPIRED and done=1, not PAUSE. clear and start together in IDLE → stays IDLE.
- Zero load and expiry blink: start with load_val=0 → EXPIRED with done=1 next cycle. blink then toggles every 4 cycles: 0→1→0. start with load_val=5 → RUN, remaining=5, blink=0.
- Clear mid-run: clear while in RUN with remaining=7 → next cycle state=IDLE, remaining=0; no done pulse; tick stays 0 afterwards.
